coeff_rate_sequencer: RTL

COEFF_RATE_SEQUENCER -- requirements
Module: coeff_rate_sequencer

---
 rtl/coeff_rate_if.sv | 37 +++
 rtl/coeff_rate_sequencer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/coeff_rate_if.sv
// Coefficient, cost-table, lookup and per-group rate signals of the coefficient rate sequencer.
interface coeff_rate_if #(
    parameter int ACC_W = 40
);
    logic              coef_valid;
    logic              coef_ready;
    logic [15:0]       coef_abs;
    logic              coef_last;
    logic              cost_rd_en;
    logic [3:0]        cost_rd_idx;
    logic [15:0]       cost_g1;
    logic [15:0]       cost_abs;
    logic              lk_start;
    logic [1:0]        lk_level_case;
    logic [7:0]        lk_c1Idx;
    logic [7:0]        lk_c2Idx;
    logic [15:0]       lk_greater_one_cost;
    logic [15:0]       lk_level_abs_cost;
    logic [31:0]       lk_context_bits;
    logic              lk_done;
    logic              rate_valid;
    logic [ACC_W-1:0]  rate_bits;
    logic [7:0]        rate_count;
    logic              err_timeout;

    modport slave (
        input  coef_valid, coef_abs, coef_last, cost_g1, cost_abs, lk_context_bits, lk_done,
        output coef_ready, cost_rd_en, cost_rd_idx, lk_start, lk_level_case, lk_c1Idx, lk_c2Idx,
               lk_greater_one_cost, lk_level_abs_cost, rate_valid, rate_bits, rate_count, err_timeout
    );

    modport master (
        output coef_valid, coef_abs, coef_last, cost_g1, cost_abs, lk_context_bits, lk_done,
        input  coef_ready, cost_rd_en, cost_rd_idx, lk_start, lk_level_case, lk_c1Idx, lk_c2Idx,
               lk_greater_one_cost, lk_level_abs_cost, rate_valid, rate_bits, rate_count, err_timeout
    );
endinterface

// File: rtl/coeff_rate_sequencer.sv
// Per-group coefficient rate accumulation: cost-table read, context-bit lookup, saturating sum.
// Define RATE_SEQ_TIMEOUT_EN to add a lookup watchdog that forces a zero step and sets err_timeout.
//
// state       | meaning
// S_IDLE      | ready for the next coefficient
// S_FETCH     | cost-table read request
// S_WAIT_COST | cost data returns, captured
// S_ISSUE     | lookup start pulse
// S_WAIT_DONE | waiting for lookup result
// S_ACC       | accumulate step, update counters, close group on last
module coeff_rate_sequencer #(
    parameter int ACC_W       = 40,
    parameter int TIMEOUT_CYC = 16
) (
    input logic         clk,
    input logic         rst_n,
    coeff_rate_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT_COST, S_ISSUE, S_WAIT_DONE, S_ACC
    } state_t;

    state_t            state_q, state_d;
    logic              run_q;
    logic [1:0]        lvl_q;
    logic              last_q;
    logic [3:0]        c1_q;
    logic              c2_q;
    logic [15:0]       g1_q, abs_q;
    logic [31:0]       step_q;
    logic [ACC_W-1:0]  acc_q;
    logic [7:0]        cnt_q;
    logic              rate_valid_q;
    logic [ACC_W-1:0]  rate_bits_q;
    logic [7:0]        rate_count_q;

    logic              xfer;
    logic              tmo_hit;
    logic [1:0]        lvl_in;
    logic [ACC_W:0]    acc_sum;
    logic [ACC_W-1:0]  acc_nxt;
    logic [7:0]        cnt_nxt;
    logic [2:0]        c1_sat;

    assign xfer    = bus.coef_valid && (state_q == S_IDLE) && run_q;
    assign acc_sum = {1'b0, acc_q} + (ACC_W+1)'(step_q);
    assign acc_nxt = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
    assign cnt_nxt = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    assign c1_sat  = (c1_q >= 4'd8) ? 3'd7 : c1_q[2:0];

    always_comb begin
        lvl_in = 2'd3;
        if (bus.coef_abs == 16'd0)      lvl_in = 2'd0;
        else if (bus.coef_abs == 16'd1) lvl_in = 2'd1;
        else if (bus.coef_abs == 16'd2) lvl_in = 2'd2;
    end

`ifdef RATE_SEQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_q;
    logic             err_q;

    // Down-counter loaded on ISSUE; terminal count in WAIT_DONE abandons the lookup.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q == S_ISSUE)
                tmo_q <= TMO_W'(TIMEOUT_CYC - 1);
            else if (state_q == S_WAIT_DONE && tmo_q != '0)
                tmo_q <= tmo_q - 1'b1;
            if (tmo_hit)
                err_q <= 1'b1;
        end
    end

    assign tmo_hit         = (state_q == S_WAIT_DONE) && !bus.lk_done && (tmo_q == '0);
    assign bus.err_timeout = err_q;
`else
    assign tmo_hit         = 1'b0;
    assign bus.err_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (xfer) state_d = (lvl_in == 2'd0) ? S_ACC : S_FETCH;
            S_FETCH:     state_d = S_WAIT_COST;
            S_WAIT_COST: state_d = S_ISSUE;
            S_ISSUE:     state_d = S_WAIT_DONE;
            S_WAIT_DONE: if (bus.lk_done || tmo_hit) state_d = S_ACC;
            S_ACC:       state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.coef_ready          = (state_q == S_IDLE) && run_q;
        bus.cost_rd_en          = (state_q == S_FETCH);
        bus.cost_rd_idx         = (state_q == S_FETCH) ? {c2_q, c1_sat} : 4'd0;
        bus.lk_start            = (state_q == S_ISSUE);
        bus.lk_level_case       = lvl_q;
        bus.lk_c1Idx            = {4'd0, c1_q};
        bus.lk_c2Idx            = {7'd0, c2_q};
        bus.lk_greater_one_cost = g1_q;
        bus.lk_level_abs_cost   = abs_q;
        bus.rate_valid          = rate_valid_q;
        bus.rate_bits           = rate_bits_q;
        bus.rate_count          = rate_count_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q        <= 1'b0;
            lvl_q        <= 2'd0;
            last_q       <= 1'b0;
            c1_q         <= 4'd0;
            c2_q         <= 1'b0;
            g1_q         <= 16'd0;
            abs_q        <= 16'd0;
            step_q       <= 32'd0;
            acc_q        <= '0;
            cnt_q        <= 8'd0;
            rate_valid_q <= 1'b0;
            rate_bits_q  <= '0;
            rate_count_q <= 8'd0;
        end else begin
            run_q        <= 1'b1;
            rate_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: if (xfer) begin
                    lvl_q  <= lvl_in;
                    last_q <= bus.coef_last;
                    if (lvl_in == 2'd0) step_q <= 32'd0;
                end
                S_WAIT_COST: begin
                    g1_q  <= bus.cost_g1;
                    abs_q <= bus.cost_abs;
                end
                S_WAIT_DONE: begin
                    if (bus.lk_done)  step_q <= bus.lk_context_bits;
                    else if (tmo_hit) step_q <= 32'd0;
                end
                S_ACC: begin
                    if (last_q) begin
                        rate_valid_q <= 1'b1;
                        rate_bits_q  <= acc_nxt;
                        rate_count_q <= cnt_nxt;
                        acc_q        <= '0;
                        cnt_q        <= 8'd0;
                        c1_q         <= 4'd0;
                        c2_q         <= 1'b0;
                    end else begin
                        acc_q <= acc_nxt;
                        cnt_q <= cnt_nxt;
                        // Counter updates use this coefficient's pre-update c1Idx.
                        if (lvl_q >= 2'd1 && c1_q != 4'd8) c1_q <= c1_q + 4'd1;
                        if (lvl_q >= 2'd2 && c1_q < 4'd8)  c2_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
